bus_owner_fsm: RTL and testbench

//  Bus-ownership controller that produces the 4-bit one-hot state vector
//  (IDLE/BBUSY/BWAIT/BFRER) consumed by the downstream case(1'b1) status decoder.

---
 rtl/bus_owner_fsm.sv | 97 +++++++++
 tb/tb_bus_owner_fsm.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_owner_fsm.sv
// Bus-ownership controller: request, wait for grant with timeout, own the bus
// until done, then hold a release interval. State is a one-hot register.
module bus_owner_fsm #(
  parameter int IDLE         = 0,
  parameter int BBUSY        = 1,
  parameter int BWAIT        = 2,
  parameter int BFRER        = 3,
  parameter int WAIT_TIMEOUT = 16,
  parameter int FREE_CYCLES  = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_i,
  input  logic             gnt_i,
  input  logic             done_i,
  input  logic             abort_i,
  output logic [3:0]       state_o,
  output logic             bus_req_o,
  output logic             bus_own_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'(1 << IDLE),
    ST_BBUSY = 4'(1 << BBUSY),
    ST_BWAIT = 4'(1 << BWAIT),
    ST_BFRER = 4'(1 << BFRER)
  } state_t;

  // One timer is shared by BWAIT and BFRER; it only ever needs to reach the larger limit minus one.
  localparam int TMAX  = (WAIT_TIMEOUT > FREE_CYCLES) ? WAIT_TIMEOUT : FREE_CYCLES;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  logic [3:0]       state;
  logic [TMR_W-1:0] tmr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign state_o   = state;
  assign bus_req_o = state[BWAIT];
  assign bus_own_o = state[BBUSY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      timeout_o <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmr <= '0;
          if (req_i) state <= ST_BWAIT;
        end
        ST_BWAIT: begin
          if (abort_i) begin
            state <= ST_IDLE;
            tmr   <= '0;
          end else if (gnt_i) begin
            state <= ST_BBUSY;
            tmr   <= '0;
          end else if (tmr == TMR_W'(WAIT_TIMEOUT - 1)) begin
            state     <= ST_BFRER;
            tmr       <= '0;
            timeout_o <= 1'b1;
            err_cnt_o <= sat_inc(err_cnt_o);
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        ST_BBUSY: begin
          tmr <= '0;
          if (done_i || abort_i) state <= ST_BFRER;
        end
        ST_BFRER: begin
          if (tmr == TMR_W'(FREE_CYCLES - 1)) begin
            state <= ST_IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        default: begin
          // Corrupted vector: recover quietly without counting it as a timeout.
          state <= ST_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_owner_fsm.sv
// Self-checking bench for bus_owner_fsm: directed scenarios plus random
// stimulus, compared each cycle against a phase/cycle-count reference model.
module tb_bus_owner_fsm;
  localparam int WT = 16;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int P_IDLE = 0, P_BUSY = 1, P_WAIT = 2, P_FREE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_i = 1'b0, gnt_i = 1'b0, done_i = 1'b0, abort_i = 1'b0;
  logic [3:0]    state_o;
  logic          bus_req_o, bus_own_o, timeout_o;
  logic [CW-1:0] err_cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles already spent in it, timeout count, pulse.
  int m_phase, m_cnt, m_err;
  bit m_to;

  bus_owner_fsm #(.WAIT_TIMEOUT(WT), .FREE_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_i(gnt_i), .done_i(done_i),
    .abort_i(abort_i), .state_o(state_o), .bus_req_o(bus_req_o),
    .bus_own_o(bus_own_o), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  wire [CW+6:0] obs = {state_o, bus_req_o, bus_own_o, timeout_o, err_cnt_o};

  function automatic void model_reset();
    m_phase = P_IDLE; m_cnt = 0; m_err = 0; m_to = 1'b0;
  endfunction

  function automatic void model_step();
    int nxt;
    nxt  = m_phase;
    m_to = 1'b0;
    case (m_phase)
      P_IDLE: if (req_i) nxt = P_WAIT;
      P_WAIT: begin
        if (abort_i) nxt = P_IDLE;
        else if (gnt_i) nxt = P_BUSY;
        else if (m_cnt + 1 >= WT) begin
          nxt  = P_FREE;
          m_to = 1'b1;
          if (m_err < (1 << CW) - 1) m_err++;
        end
      end
      P_BUSY: if (done_i || abort_i) nxt = P_FREE;
      default: if (m_cnt + 1 >= FC) nxt = P_IDLE;
    endcase
    m_cnt   = (nxt == m_phase) ? m_cnt + 1 : 0;
    m_phase = nxt;
  endfunction

  function automatic logic [CW+6:0] expect_vec();
    return {4'(1 << m_phase), (m_phase == P_WAIT), (m_phase == P_BUSY), m_to, CW'(m_err)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    req_i = 1'b0; gnt_i = 1'b0; done_i = 1'b0; abort_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req_i = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if ({state_o, bus_req_o, bus_own_o, timeout_o, err_cnt_o} !== {4'b0001, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs, {4'b0001, 3'b000, 8'h00});
    end
    do_reset();
  endtask

  task automatic test_normal();
    logic [3:0] seq [12] = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0010,
                             4'b0010, 4'b0010, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
    for (int c = 0; c < 12; c++) begin
      req_i = (c == 0); gnt_i = (c == 3); done_i = (c == 8);
      tick();
      checks++;
      if (obs !== expect_vec()) begin
        errors++;
        $display("FAIL normal_model cyc=%0d got=%h exp=%h", c, obs, expect_vec());
      end
      checks++;
      if ({state_o, timeout_o} !== {seq[c], 1'b0}) begin
        errors++;
        $display("FAIL normal_seq cyc=%0d got=%b/%b exp=%b/0", c, state_o, timeout_o, seq[c]);
      end
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    req_i = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      checks++;
      if (obs !== expect_vec()) begin
        errors++;
        $display("FAIL timeout_model cyc=%0d got=%h exp=%h", c, obs, expect_vec());
      end
      if (state_o == 4'b0100) n++;
      else if (n > 0) break;
    end
    checks++;
    if (n !== WT || state_o !== 4'b1000 || timeout_o !== 1'b1 || err_cnt_o !== 8'd1) begin
      errors++;
      $display("FAIL timeout_first wait=%0d state=%b to=%b err=%0d exp wait=%0d state=1000 to=1 err=1",
               n, state_o, timeout_o, err_cnt_o, WT);
    end
    // Held request keeps cycling BFRER -> IDLE -> BWAIT -> timeout.
    for (int c = 0; c < 260 * (WT + FC + 1); c++) begin
      tick();
      checks++;
      if (obs !== expect_vec()) begin
        errors++;
        $display("FAIL timeout_loop cyc=%0d got=%h exp=%h", c, obs, expect_vec());
      end
    end
    checks++;
    if (err_cnt_o !== 8'hFF) begin
      errors++;
      $display("FAIL timeout_saturate got=%h exp=ff", err_cnt_o);
    end
    req_i = 1'b0;
    for (int c = 0; c < WT + FC + 2; c++) tick();
    checks++;
    if (obs !== expect_vec() || state_o !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_drain got=%h exp=%h", obs, expect_vec());
    end
  endtask

  task automatic test_simultaneous();
    logic [CW-1:0] saved;
    do_reset();
    req_i = 1'b1; tick(); req_i = 1'b0;
    tick(); tick();
    abort_i = 1'b1; gnt_i = 1'b1; tick(); clear_inputs();
    checks++;
    if (state_o !== 4'b0001 || obs !== expect_vec()) begin
      errors++;
      $display("FAIL simul_abort_gnt got=%h exp state=0001 vec=%h", obs, expect_vec());
    end
    saved = err_cnt_o;
    req_i = 1'b1; tick(); req_i = 1'b0;
    for (int c = 0; c < WT - 1; c++) tick();
    gnt_i = 1'b1; tick(); gnt_i = 1'b0;
    checks++;
    if (state_o !== 4'b0010 || timeout_o !== 1'b0 || err_cnt_o !== saved || obs !== expect_vec()) begin
      errors++;
      $display("FAIL simul_gnt_on_timeout got=%b/%b/%0d exp=0010/0/%0d", state_o, timeout_o, err_cnt_o, saved);
    end
    done_i = 1'b1; tick(); done_i = 1'b0;
    for (int c = 0; c < FC + 1; c++) tick();
  endtask

  task automatic test_abort_busy();
    int n;
    req_i = 1'b1; tick(); req_i = 1'b0;
    gnt_i = 1'b1; tick(); gnt_i = 1'b0;
    done_i = 1'b1; abort_i = 1'b1; tick(); clear_inputs();
    n = 0;
    for (int c = 0; c < 10 && state_o == 4'b1000; c++) begin
      checks++;
      if (obs !== expect_vec()) begin
        errors++;
        $display("FAIL abort_busy_model cyc=%0d got=%h exp=%h", c, obs, expect_vec());
      end
      n++;
      tick();
    end
    checks++;
    if (n !== FC || state_o !== 4'b0001) begin
      errors++;
      $display("FAIL abort_busy_free cycles=%0d state=%b exp cycles=%0d state=0001", n, state_o, FC);
    end
  endtask

  task automatic test_async_reset();
    req_i = 1'b1; tick(); req_i = 1'b0;
    gnt_i = 1'b1; tick(); gnt_i = 1'b0;
    checks++;
    if (state_o !== 4'b0010) begin
      errors++;
      $display("FAIL async_setup got=%b exp=0010", state_o);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (state_o !== 4'b0001 || bus_own_o !== 1'b0 || err_cnt_o !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got=%b own=%b err=%0d exp=0001 own=0 err=0", state_o, bus_own_o, err_cnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    logic [CW-1:0] saved;
    clear_inputs();
    tick();
    saved = err_cnt_o;
    force dut.state = 4'b0110;
    #1 release dut.state;
    tick();
    checks++;
    if (state_o !== 4'b0001 || err_cnt_o !== saved) begin
      errors++;
      $display("FAIL illegal_recover got=%b err=%0d exp=0001 err=%0d", state_o, err_cnt_o, saved);
    end
    // Model is resynchronised to IDLE with its timeout count intact.
    m_phase = P_IDLE; m_cnt = 0; m_to = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req_i   = ($urandom_range(0, 1) == 0);
      gnt_i   = ($urandom_range(0, 7) == 0);
      done_i  = ($urandom_range(0, 3) == 0);
      abort_i = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (obs !== expect_vec() || $countones(state_o) != 1) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs, expect_vec());
      end
    end
    clear_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_normal();
    test_timeout();
    test_simultaneous();
    test_abort_busy();
    test_async_reset();
    test_illegal();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
